// File: rtl/mac_pkg.sv
// Shared types and constants for the 8-lane fp32 MAC tree and its feeder.
package mac_pkg;

  localparam int unsigned LANES   = 8;
  localparam int unsigned FP_W    = 32;
  localparam int unsigned CHUNK_W = LANES * FP_W;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

  typedef logic [CHUNK_W-1:0] chunk_t;

  // One A/B operand pair as presented to the tree lanes.
  typedef struct packed {
    chunk_t a;
    chunk_t b;
  } operand_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_HOLD
  } feeder_state_t;

endpackage

// File: rtl/mac_tree_feeder_if.sv
// Job, operand-stream, tree-lane and result signals of mac_tree_feeder.
interface mac_tree_feeder_if
  import mac_pkg::*;
#(
  parameter int unsigned LEN_W = 16
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  chunk_t           in_a;
  chunk_t           in_b;
  logic             mac_clr;
  chunk_t           mac_a;
  chunk_t           mac_b;
  logic [FP_W-1:0]  mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [FP_W-1:0]  res_data;

  modport master (
    output start, len, in_valid, in_a, in_b, mac_out, res_ready,
    input  busy, in_ready, mac_clr, mac_a, mac_b, res_valid, res_data
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, mac_out, res_ready,
    output busy, in_ready, mac_clr, mac_a, mac_b, res_valid, res_data
  );

endinterface

// File: rtl/mac_lane_mask.sv
// Lane enable for the final, partially filled chunk of an element-counted job.
module mac_lane_mask
  import mac_pkg::*;
(
  input  logic [2:0]       tail,
  input  logic             last,
  output logic [LANES-1:0] lane_en
);

  always_comb begin
    lane_en = '1;
    if (last && (tail != 3'd0)) begin
      for (int i = 0; i < LANES; i++) begin
        lane_en[i] = (3'(i) < tail);
      end
    end
  end

endmodule

// File: rtl/mac_tree_feeder.sv
// Operand sequencer for the 8-lane fp32 MAC tree: clear, feed, drain, hold result.
// Define MAC_TREE_FEEDER_TAIL_MASK_EN to count len in elements and zero unused tail lanes.
module mac_tree_feeder
  import mac_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned CLR_CYC   = 8,
  parameter int unsigned DRAIN_LAT = 40
)(
  input logic              clk,
  input logic              rst_n,
  mac_tree_feeder_if.slave bus
);

  localparam int unsigned CNT_MAX = (CLR_CYC > DRAIN_LAT) ? CLR_CYC : DRAIN_LAT;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  feeder_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] chunks_left;
  logic             busy_q;
  logic             in_ready_q;
  logic             mac_clr_q;
  logic             res_valid_q;
  logic [FP_W-1:0]  res_data_q;
  operand_t         lane_q;

  logic             hs_c;
  logic [LEN_W-1:0] job_chunks_c;
  logic [LANES-1:0] lane_en_c;
  operand_t         chunk_c;

  assign hs_c = in_ready_q & bus.in_valid;

`ifdef MAC_TREE_FEEDER_TAIL_MASK_EN
  logic [2:0] tail_q;

  assign job_chunks_c = (bus.len >> 3) + LEN_W'(bus.len[2:0] != 3'd0);

  // Element count remainder, kept for masking the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q <= 3'd0;
    end else if ((state == ST_IDLE) && bus.start) begin
      tail_q <= bus.len[2:0];
    end
  end

  mac_lane_mask u_lane_mask (
    .tail    (tail_q),
    .last    (chunks_left == LEN_W'(1)),
    .lane_en (lane_en_c)
  );
`else
  assign job_chunks_c = bus.len;
  assign lane_en_c    = '1;
`endif

  // Next lane drive: accepted chunk with masked lanes zeroed, +0.0 otherwise.
  always_comb begin
    chunk_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (hs_c && lane_en_c[i]) begin
        chunk_c.a[i*FP_W +: FP_W] = bus.in_a[i*FP_W +: FP_W];
        chunk_c.b[i*FP_W +: FP_W] = bus.in_b[i*FP_W +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      chunks_left <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mac_clr_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= FP_ZERO;
      lane_q      <= '0;
    end else begin
      mac_clr_q <= 1'b0;
      lane_q    <= chunk_c;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            chunks_left <= job_chunks_c;
            busy_q      <= 1'b1;
            if (job_chunks_c == '0) begin
              res_data_q  <= FP_ZERO;
              res_valid_q <= 1'b1;
              state       <= ST_HOLD;
            end else begin
              cnt       <= CNT_W'(CLR_CYC);
              mac_clr_q <= 1'b1;
              state     <= ST_CLEAR;
            end
          end
        end
        // Clear is held for exactly CLR_CYC cycles.
        ST_CLEAR: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            in_ready_q <= 1'b1;
            state      <= ST_FEED;
          end else begin
            mac_clr_q <= 1'b1;
          end
        end
        ST_FEED: begin
          if (hs_c) begin
            chunks_left <= chunks_left - LEN_W'(1);
            if (chunks_left == LEN_W'(1)) begin
              in_ready_q <= 1'b0;
              cnt        <= CNT_W'(DRAIN_LAT);
              state      <= ST_DRAIN;
            end
          end
        end
        // DRAIN_LAT cycles after the last lane issue the tree output is final.
        ST_DRAIN: begin
          if (cnt == '0) begin
            res_data_q  <= bus.mac_out;
            res_valid_q <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_a     = lane_q.a;
  assign bus.mac_b     = lane_q.b;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_tree_feeder.sv
// Bench for mac_tree_feeder: integer-valued fp32 tree model, job-level scoreboard, directed jobs.
// Honours MAC_TREE_FEEDER_TAIL_MASK_EN for length units and the tail-mask job.
module tb_mac_tree_feeder;
  import mac_pkg::*;

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned CLR_CYC   = 8;
  localparam int unsigned DRAIN_LAT = 40;
  localparam int unsigned TREE_PIPE = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_count = 0;
  int   clr_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count++;

  mac_tree_feeder_if #(.LEN_W(LEN_W)) bus ();

  mac_tree_feeder #(
    .LEN_W     (LEN_W),
    .CLR_CYC   (CLR_CYC),
    .DRAIN_LAT (DRAIN_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---- fp32 helpers valid for non-negative integer values ----
  function automatic int unsigned fp_to_int(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]);
    m = {1'b1, f[22:0]};
    if (e >= 150) return int'(m) << (e - 150);
    return int'(m >> (150 - e));
  endfunction

  function automatic logic [31:0] int_to_fp(input int unsigned v);
    int p;
    logic [31:0] mant;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    mant = (p >= 23) ? (v >> (p - 23)) : (v << (23 - p));
    return {1'b0, 8'(127 + p), mant[22:0]};
  endfunction

  function automatic int unsigned chunk_dot(input chunk_t a, input chunk_t b, input logic [LANES-1:0] en);
    int unsigned s = 0;
    for (int i = 0; i < LANES; i++)
      if (en[i]) s += fp_to_int(a[i*FP_W +: FP_W]) * fp_to_int(b[i*FP_W +: FP_W]);
    return s;
  endfunction

  function automatic chunk_t mask_chunk(input chunk_t c, input logic [LANES-1:0] en);
    chunk_t r = '0;
    for (int i = 0; i < LANES; i++)
      if (en[i]) r[i*FP_W +: FP_W] = c[i*FP_W +: FP_W];
    return r;
  endfunction

  function automatic int chunks_of(input logic [LEN_W-1:0] l);
`ifdef MAC_TREE_FEEDER_TAIL_MASK_EN
    return (int'(l) + 7) / 8;
`else
    return int'(l);
`endif
  endfunction

  // Job length for n full chunks in whichever unit len uses.
  function automatic logic [LEN_W-1:0] len_for(input int n);
`ifdef MAC_TREE_FEEDER_TAIL_MASK_EN
    return LEN_W'(n * 8);
`else
    return LEN_W'(n);
`endif
  endfunction

  task automatic check(input string name, input logic [CHUNK_W-1:0] act, input logic [CHUNK_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- MAC tree stand-in: integer accumulator behind a fixed pipeline ----
  int unsigned tree_acc = 0;
  logic [31:0] tree_pipe [TREE_PIPE];
  initial for (int i = 0; i < TREE_PIPE; i++) tree_pipe[i] = 32'h0;

  always @(posedge clk) begin
    if (bus.mac_clr) tree_acc <= 0;
    else             tree_acc <= tree_acc + chunk_dot(bus.mac_a, bus.mac_b, '1);
    tree_pipe[0] <= int_to_fp(tree_acc);
    for (int i = 1; i < TREE_PIPE; i++) tree_pipe[i] <= tree_pipe[i-1];
    bus.mac_out <= tree_pipe[TREE_PIPE-1];
  end

  // ---- job-level model: timing from cycles since start, result from accepted operands ----
  logic             m_active, m_hs_now;
  int               m_cyc, m_n, m_hs, m_tlast;
  int unsigned      m_acc;
  logic [LEN_W-1:0] m_len;
  logic [LANES-1:0] m_en;
  logic             e_busy, e_clr, e_rdy, e_rv;
  logic [31:0]      e_rd;
  chunk_t           e_a, e_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      e_busy = 1'b0; e_clr = 1'b1; e_rdy = 1'b0; e_rv = 1'b0; e_rd = 32'h0;
      e_a = '0; e_b = '0;
    end else begin
      m_hs_now = m_active && e_rdy && bus.in_valid;
      m_en = '1;
`ifdef MAC_TREE_FEEDER_TAIL_MASK_EN
      for (int i = 0; i < LANES; i++) m_en[i] = ((m_hs * 8 + i) < int'(m_len));
`endif
      e_a = '0; e_b = '0;
      if (m_hs_now) begin
        e_a = mask_chunk(bus.in_a, m_en);
        e_b = mask_chunk(bus.in_b, m_en);
        m_acc += chunk_dot(bus.in_a, bus.in_b, m_en);
        m_hs++;
        if (m_hs == m_n) m_tlast = m_cyc;
      end
      if (m_active && e_rv && bus.res_ready) m_active = 1'b0;
      else if (m_active) m_cyc++;
      else if (bus.start) begin
        m_active = 1'b1; m_cyc = 1; m_n = chunks_of(bus.len);
        m_hs = 0; m_acc = 0; m_len = bus.len; m_tlast = 0;
      end
      e_busy = m_active;
      e_clr  = m_active && (m_n != 0) && (m_cyc <= CLR_CYC);
      e_rdy  = m_active && (m_cyc > CLR_CYC) && (m_hs < m_n);
      e_rv   = m_active && ((m_n == 0) || ((m_hs == m_n) && (m_cyc >= m_tlast + DRAIN_LAT + 2)));
      if (e_rv) e_rd = int_to_fp(m_acc);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, e_busy);
      check("in_ready", bus.in_ready, e_rdy);
      check("mac_clr", bus.mac_clr, e_clr);
      check("mac_a", bus.mac_a, e_a);
      check("mac_b", bus.mac_b, e_b);
      check("res_valid", bus.res_valid, e_rv);
      if (e_rv) check("res_data", bus.res_data, e_rd);
      if (bus.mac_clr) clr_seen++;
    end
  end

  // ---- stimulus ----
  function automatic chunk_t splat(input logic [31:0] v);
    chunk_t c;
    for (int i = 0; i < LANES; i++) c[i*FP_W +: FP_W] = v;
    return c;
  endfunction

  task automatic run_job(input logic [LEN_W-1:0] l, input bit bubbles, input chunk_t a, input chunk_t b,
                         output int lat, output logic [31:0] data);
    int t0, sent, guard, nch;
    bit tog, r, v;
    nch = chunks_of(l);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = l; bus.in_a = a; bus.in_b = b;
    t0 = cyc_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    sent = 0; guard = 0; tog = 1'b1;
    while (sent < nch && guard < 500) begin
      r = bus.in_ready;
      v = bubbles ? tog : 1'b1;
      if (r) tog = ~tog;
      bus.in_valid = v;
      @(posedge clk); #1;
      if (r && v) sent++;
      guard++;
    end
    bus.in_valid = 1'b0;
    check("handshakes", 256'(sent), 256'(nch));
    guard = 0;
    while (!bus.res_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    lat  = bus.res_valid ? (cyc_count - t0) : -1;
    data = bus.res_data;
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] data;
    chunk_t ramp;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_mac_clr", bus.mac_clr, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_res_data", bus.res_data, 32'h0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("clr_after_release", bus.mac_clr, 1'b0);

    // empty job
    clr_seen = 0;
    run_job('0, 1'b0, '0, '0, lat, data);
    check("empty_latency", 256'(lat), 256'(1));
    check("empty_data", data, 32'h0);
    take_result();
    check("empty_no_clr", 256'(clr_seen), 256'(0));

    // two chunks of 1.0*2.0, no bubbles
    run_job(len_for(2), 1'b0, splat(32'h3F800000), splat(32'h40000000), lat, data);
    check("two_latency", 256'(lat), 256'(1 + CLR_CYC + 2 + DRAIN_LAT + 1));
    check("two_data", data, 32'h42000000);
    take_result();

    // same job with bubbles, result ready raised early
    bus.res_ready = 1'b1;
    run_job(len_for(2), 1'b1, splat(32'h3F800000), splat(32'h40000000), lat, data);
    check("bubble_data", data, 32'h42000000);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("early_ready_idle", bus.busy, 1'b0);

    // three chunks of 3.0*4.0
    run_job(len_for(3), 1'b0, splat(32'h40400000), splat(32'h40800000), lat, data);
    check("three_latency", 256'(lat), 256'(53));
    check("three_data", data, 32'h43900000);
    take_result();

    // per-lane ramp 1..8 against 1.0, two chunks: 2*36 = 72.0
    for (int i = 0; i < LANES; i++) ramp[i*FP_W +: FP_W] = int_to_fp(i + 1);
    run_job(len_for(2), 1'b0, ramp, splat(32'h3F800000), lat, data);
    check("ramp_data", data, 32'h42900000);
    take_result();

    // result backpressure with start pulses
    run_job(len_for(1), 1'b0, splat(32'h3F800000), splat(32'h3F800000), lat, data);
    for (int k = 0; k < 10; k++) begin
      bus.start = ~k[0]; bus.len = len_for(5);
      @(posedge clk); #1;
      check("bp_busy", bus.busy, 1'b1);
      check("bp_valid", bus.res_valid, 1'b1);
      check("bp_data", bus.res_data, 32'h41000000);
    end
    bus.start = 1'b0;
    take_result();
    check("bp_idle_busy", bus.busy, 1'b0);
    check("bp_idle_valid", bus.res_valid, 1'b0);

    // reset in the middle of feeding
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = len_for(4); bus.in_a = splat(32'h3F800000); bus.in_b = splat(32'h3F800000);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1;
    for (int g = 0; g < 50 && !bus.in_ready; g++) begin
      @(posedge clk); #1;
    end
    check("mid_feeding", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ready", bus.in_ready, 1'b0);
    check("mid_rst_clr", bus.mac_clr, 1'b1);
    check("mid_rst_mac_a", bus.mac_a, '0);
    check("mid_rst_valid", bus.res_valid, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job(len_for(1), 1'b0, splat(32'h3F800000), splat(32'h3F800000), lat, data);
    check("after_rst_data", data, 32'h41000000);
    take_result();

`ifdef MAC_TREE_FEEDER_TAIL_MASK_EN
    run_job(LEN_W'(11), 1'b0, splat(32'h3F800000), splat(32'h3F800000), lat, data);
    check("tail_data", data, 32'h41300000);
    take_result();
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1);
  end

endmodule
